// File: rtl/gpio_pkg.sv
// Shared GPIO constants: clock/debounce timing defaults and the switch-bit
// indices the Processor uses for its run/step/reset controls.
package gpio_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 1;

    // Default prescaler period: one sample tick per DEBOUNCE_MS.
    localparam int TICK_DIV_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // Switch-bit positions consumed by the Processor.
    localparam int SW_RUN       = 0;
    localparam int SW_STEP      = 1;
    localparam int SW_CPU_RESET = 2;

    // Width of a counter that must hold 0..div-1 (div is at least 2).
    function automatic int tick_cnt_width(input int div);
        int w;
        w = $clog2(div);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch bus between the GPIO expansion board and the debouncer:
// raw levels in, clean levels, edge pulses and the sample strobe out.
interface switch_debouncer_if #(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             any_change;
    logic             sample_tick;

    // Source side: drives raw switches, consumes conditioned outputs.
    modport master (
        output sw_raw,
        input  sw_stable,
        input  sw_rise,
        input  sw_fall,
        input  any_change,
        input  sample_tick
    );

    // Debouncer side.
    modport slave (
        input  sw_raw,
        output sw_stable,
        output sw_rise,
        output sw_fall,
        output any_change,
        output sample_tick
    );

endinterface

// File: rtl/debounce_cell.sv
// One switch bit's stability filter: shifts in the synchronised level on
// every sample tick and accepts a new level only after STABLE_SAMPLES equal
// samples in a row, emitting a one-cycle rise or fall pulse on acceptance.
module debounce_cell #(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic change_next
);

    // Only the previous STABLE_SAMPLES-1 samples need storing; the current
    // sample completes the window combinationally.
    localparam int HW = STABLE_SAMPLES - 1;

    logic [HW-1:0]             hist_r;
    logic                      stable_r;
    logic                      rise_r;
    logic                      fall_r;
    logic [STABLE_SAMPLES-1:0] next_hist_s;
    logic                      all_ones_s;
    logic                      all_zeros_s;
    logic                      rise_next_s;
    logic                      fall_next_s;

    // Build the sample window and decide whether a new level is accepted.
    always_comb begin
        next_hist_s = {hist_r, din};
        all_ones_s  = &next_hist_s;
        all_zeros_s = ~|next_hist_s;
        if (tick) begin
            rise_next_s = all_ones_s & ~stable_r;
            fall_next_s = all_zeros_s & stable_r;
        end else begin
            rise_next_s = 1'b0;
            fall_next_s = 1'b0;
        end
    end

    // History, accepted level and single-cycle edge pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_r   <= {HW{1'b0}};
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            rise_r <= rise_next_s;
            fall_r <= fall_next_s;
            if (tick) begin
                hist_r <= next_hist_s[HW-1:0];
            end else begin
                hist_r <= hist_r;
            end
            if (rise_next_s) begin
                stable_r <= 1'b1;
            end else if (fall_next_s) begin
                stable_r <= 1'b0;
            end else begin
                stable_r <= stable_r;
            end
        end
    end

    assign stable      = stable_r;
    assign rise        = rise_r;
    assign fall        = fall_r;
    assign change_next = rise_next_s | fall_next_s;

endmodule

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: two-flop synchroniser, shared sample-tick
// prescaler and one stability filter per bit, producing clean levels and
// one-cycle rise/fall pulses for the LED loopback and the Processor.
module switch_debouncer
    import gpio_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TICK_DIV       = TICK_DIV_DEFAULT,
    parameter int STABLE_SAMPLES = 4
) (
    input logic               clock,
    input logic               reset,
    switch_debouncer_if.slave bus
);

    localparam int               CNT_W    = tick_cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [CNT_W-1:0] tick_cnt_r;
    logic [CNT_W-1:0] tick_cnt_next_s;
    logic             tick_wrap_s;
    logic             tick_r;
    logic             any_change_r;
    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] change_next_s;

    // Two-flop synchroniser; only the second stage reaches the filters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= {WIDTH{1'b0}};
            sync2_r <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= bus.sw_raw;
            sync2_r <= sync1_r;
        end
    end

    // Prescaler next-state: wrap at TICK_DIV-1 and flag the wrap.
    always_comb begin
        if (tick_cnt_r == CNT_LAST) begin
            tick_cnt_next_s = CNT_ZERO;
            tick_wrap_s     = 1'b1;
        end else begin
            tick_cnt_next_s = tick_cnt_r + CNT_ONE;
            tick_wrap_s     = 1'b0;
        end
    end

    // Prescaler counter and registered one-cycle sample strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= CNT_ZERO;
            tick_r     <= 1'b0;
        end else begin
            tick_cnt_r <= tick_cnt_next_s;
            tick_r     <= tick_wrap_s;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_cell
            debounce_cell #(
                .STABLE_SAMPLES(STABLE_SAMPLES)
            ) u_cell (
                .clock       (clock),
                .reset       (reset),
                .tick        (tick_r),
                .din         (sync2_r[gi]),
                .stable      (stable_s[gi]),
                .rise        (rise_s[gi]),
                .fall        (fall_s[gi]),
                .change_next (change_next_s[gi])
            );
        end
    endgenerate

    // Summary change pulse, registered alongside the per-bit pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            any_change_r <= 1'b0;
        end else begin
            any_change_r <= |change_next_s;
        end
    end

    assign bus.sw_stable   = stable_s;
    assign bus.sw_rise     = rise_s;
    assign bus.sw_fall     = fall_s;
    assign bus.any_change  = any_change_r;
    assign bus.sample_tick = tick_r;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (WIDTH=4, TICK_DIV=4,
// STABLE_SAMPLES=3): a run-length reference model feeds a scoreboard queue
// every clock, plus directed timing checks on the interesting scenarios.
module tb_switch_debouncer;

    localparam int W  = 4;
    localparam int TD = 4;
    localparam int SS = 3;

    logic clock;
    logic reset;

    switch_debouncer_if #(.WIDTH(W)) bus_if ();

    switch_debouncer #(
        .WIDTH          (W),
        .TICK_DIV       (TD),
        .STABLE_SAMPLES (SS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef logic [13:0] exp_t;   // {tick, any, fall[3:0], rise[3:0], stable[3:0]}
    exp_t sb_q[$];

    logic [W-1:0] m_sync1, m_sync2, m_stable, m_rise, m_fall, m_last;
    logic         m_tick, m_any;
    int           m_cnt;
    int           m_run [W];

    always @(posedge clock) begin
        logic       old_tick;
        logic [W-1:0] old_sync2;
        if (reset) begin
            m_sync1 = '0; m_sync2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
            m_tick = 1'b0; m_any = 1'b0; m_cnt = 0; m_last = '0;
            for (int i = 0; i < W; i++) m_run[i] = SS - 1;   // cleared history reads as zeros
        end else begin
            old_tick  = m_tick;
            old_sync2 = m_sync2;
            m_tick  = (m_cnt == TD - 1);
            m_cnt   = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
            m_sync2 = m_sync1;
            m_sync1 = bus_if.sw_raw;
            m_rise  = '0;
            m_fall  = '0;
            if (old_tick) begin
                for (int i = 0; i < W; i++) begin
                    if (old_sync2[i] == m_last[i]) begin
                        if (m_run[i] < SS) m_run[i] = m_run[i] + 1;
                    end else begin
                        m_last[i] = old_sync2[i];
                        m_run[i]  = 1;
                    end
                    if (m_run[i] >= SS && old_sync2[i] && !m_stable[i]) begin
                        m_rise[i] = 1'b1; m_stable[i] = 1'b1;
                    end else if (m_run[i] >= SS && !old_sync2[i] && m_stable[i]) begin
                        m_fall[i] = 1'b1; m_stable[i] = 1'b0;
                    end
                end
            end
            m_any = |(m_rise | m_fall);
        end
        sb_q.push_back({m_tick, m_any, m_fall, m_rise, m_stable});
    end

    // Pop the expectation for the edge just taken and compare on the far edge.
    always @(negedge clock) begin
        exp_t e;
        exp_t g;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            g = {bus_if.sample_tick, bus_if.any_change, bus_if.sw_fall, bus_if.sw_rise, bus_if.sw_stable};
            check_val("cycle", {18'd0, g}, {18'd0, e});
        end
    end

    // Pulse counters used by the directed scenarios.
    int rise_cnt [W];
    int fall_cnt [W];
    always @(negedge clock) begin
        for (int i = 0; i < W; i++) begin
            if (bus_if.sw_rise[i]) rise_cnt[i] = rise_cnt[i] + 1;
            if (bus_if.sw_fall[i]) fall_cnt[i] = fall_cnt[i] + 1;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int tick_at [$];
        int chg_at;
        logic [W-1:0] chg_rise;
        int hit;
        int base_r, base_f;

        for (int i = 0; i < W; i++) begin rise_cnt[i] = 0; fall_cnt[i] = 0; end
        reset = 1'b1;
        bus_if.sw_raw = 4'hF;
        repeat (3) @(negedge clock);
        check_val("reset_outs", {18'd0, bus_if.sample_tick, bus_if.any_change, bus_if.sw_fall,
                  bus_if.sw_rise, bus_if.sw_stable}, 32'd0);

        // Release; record tick edges and the power-on rise.
        @(negedge clock); #1 reset = 1'b0;
        chg_at = -1; chg_rise = '0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (bus_if.sample_tick) tick_at.push_back(n);
            if (bus_if.any_change && chg_at < 0) begin chg_at = n; chg_rise = bus_if.sw_rise; end
        end
        check_val("tick_count", tick_at.size(), 32'd5);
        if (tick_at.size() >= 3) begin
            check_val("tick_first", tick_at[0], 32'd4);
            check_val("tick_second", tick_at[1], 32'd8);
            check_val("tick_third", tick_at[2], 32'd12);
        end
        check_val("poweron_edge", chg_at, 32'd13);
        check_val("poweron_rise", {28'd0, chg_rise}, 32'hF);

        // Return to all-low before the clean rise.
        bus_if.sw_raw = 4'h0;
        repeat (20) step();
        check_val("settle_low", {28'd0, bus_if.sw_stable}, 32'h0);

        // Clean rise on bit 0.
        base_r = rise_cnt[0]; base_f = fall_cnt[0];
        bus_if.sw_raw[0] = 1'b1;
        hit = 0;
        for (int n = 1; n <= 30 && hit == 0; n++) begin
            step();
            if (bus_if.sw_stable[0]) begin
                hit = n;
                check_val("rise0_pulse", {30'd0, bus_if.sw_rise[0], bus_if.any_change}, 32'h3);
            end
        end
        check_val("rise0_latency_ok", (hit >= 11 && hit <= 14) ? 32'd1 : 32'd0, 32'd1);
        repeat (20) step();
        check_val("rise0_count", rise_cnt[0] - base_r, 32'd1);
        check_val("rise0_nofall", fall_cnt[0] - base_f, 32'd0);

        // Bounce rejection on bit 1.
        base_r = rise_cnt[1]; base_f = fall_cnt[1];
        for (int k = 0; k < 12; k++) begin
            bus_if.sw_raw[1] = ~bus_if.sw_raw[1];
            repeat (5) step();
        end
        bus_if.sw_raw[1] = 1'b0;
        repeat (20) step();
        check_val("bounce_stable", {31'd0, bus_if.sw_stable[1]}, 32'd0);
        check_val("bounce_rises", rise_cnt[1] - base_r, 32'd0);
        check_val("bounce_falls", fall_cnt[1] - base_f, 32'd0);

        // Clean fall on bit 2.
        bus_if.sw_raw[2] = 1'b1;
        repeat (16) step();
        check_val("fall2_pre", {31'd0, bus_if.sw_stable[2]}, 32'd1);
        base_f = fall_cnt[2];
        bus_if.sw_raw[2] = 1'b0;
        hit = 0;
        for (int n = 1; n <= 30 && hit == 0; n++) begin
            step();
            if (!bus_if.sw_stable[2]) begin
                hit = n;
                check_val("fall2_pulse", {31'd0, bus_if.sw_fall[2]}, 32'd1);
            end
        end
        check_val("fall2_latency_ok", (hit >= 11 && hit <= 14) ? 32'd1 : 32'd0, 32'd1);
        repeat (20) step();
        check_val("fall2_count", fall_cnt[2] - base_f, 32'd1);

        // Simultaneous rise on bits 1 and 3.
        bus_if.sw_raw = 4'h0;
        repeat (20) step();
        bus_if.sw_raw = 4'b1010;
        hit = 0;
        for (int n = 1; n <= 30 && hit == 0; n++) begin
            step();
            if (bus_if.any_change) begin
                hit = n;
                check_val("simul_rise", {28'd0, bus_if.sw_rise}, 32'hA);
                check_val("simul_fall", {28'd0, bus_if.sw_fall}, 32'h0);
            end
        end
        check_val("simul_seen", (hit > 0) ? 32'd1 : 32'd0, 32'd1);
        step();
        check_val("simul_one_cycle", {28'd0, bus_if.sw_rise}, 32'h0);

        // Reset mid-window on bit 3.
        bus_if.sw_raw = 4'h0;
        repeat (20) step();
        base_r = rise_cnt[3];
        bus_if.sw_raw[3] = 1'b1;
        repeat (2 * TD) step();
        @(negedge clock); #1 reset = 1'b1;
        @(negedge clock); #1 reset = 1'b0;
        check_val("midrst_no_pulse", rise_cnt[3] - base_r, 32'd0);
        hit = 0;
        for (int n = 1; n <= 30 && hit == 0; n++) begin
            step();
            if (bus_if.sw_rise[3]) hit = n;
        end
        check_val("midrst_rise_edge", hit, 32'd13);
        repeat (5) step();
        check_val("midrst_rise_count", rise_cnt[3] - base_r, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the raw slide-switch bus that GPIO_Board returns from the expansion board before anything else consumes it.
- Processing chain: two-flop synchroniser, then a shared sample-tick prescaler, then per-bit N-sample stability filter.
- Delivers clean levels plus one-cycle rise/fall pulses.
- Consumers are the LED loopback logic and the Processor (run/step/reset controls), so no consumer ever sees bounce or metastable inputs.

Parameters:
- WIDTH, 32, number of switch bits.
- TICK_DIV, 50000, clock cycles per sample tick (1 ms at 50 MHz); legal range ≥2.
- STABLE_SAMPLES, 4, consecutive equal samples needed to accept a new level; legal range 2..16.

Ports:
- clock, input, 1, system clock (50 MHz CLOCK_50 domain).
- reset, input, 1, asynchronous, active-high; clears all state.
- sw_raw, input, WIDTH, unsynchronised switch levels from GPIO_Board.
- sw_stable, output, WIDTH, debounced switch levels.
- sw_rise, output, WIDTH, one-cycle pulse per bit on an accepted 0→1 transition.
- sw_fall, output, WIDTH, one-cycle pulse per bit on an accepted 1→0 transition.
- any_change, output, 1, OR of sw_rise|sw_fall, same cycle.
- sample_tick, output, 1, one-cycle strobe when the prescaler wraps (observability; also usable by the Processor as a 1 ms timebase).

Behaviour:
- Reset (asynchronous assert, synchronous-to-clock deassert expected from the source):
  - sync stages, history registers, prescaler, sw_stable, sw_rise, sw_fall, any_change and sample_tick are all 0.
- Synchroniser: sync1 <= sw_raw; sync2 <= sync1. Only sync2 feeds the filter.
- Prescaler:
  - Counter 0..TICK_DIV-1, increments every clock.
  - At TICK_DIV-1 it wraps to 0 and sample_tick = 1 for exactly that cycle (registered).
  - Tick period is exactly TICK_DIV cycles; the first tick comes TICK_DIV cycles after reset release.
- Per-bit filter, evaluated only on a tick cycle:
  - next_hist = {hist[STABLE_SAMPLES-2:0], sync2[i]}; hist <= next_hist.
  - If next_hist is all ones and sw_stable[i] == 0: sw_stable[i] <= 1 and sw_rise[i] <= 1 on the same edge.
  - If next_hist is all zeros and sw_stable[i] == 1: sw_stable[i] <= 0 and sw_fall[i] <= 1 on the same edge.
  - Otherwise sw_stable[i] holds.
- Pulses:
  - sw_rise, sw_fall and any_change are registered and high for exactly one clock.
  - They are cleared on the next edge unconditionally.
  - At most one of rise/fall per bit per tick.
- Latency, for a raw level held steady: sw_stable follows after 2 cycles plus between (STABLE_SAMPLES-1)·TICK_DIV+1 and STABLE_SAMPLES·TICK_DIV cycles.
- Boundary cases:
  - Any mismatch inside the window restarts acceptance; a bit toggling faster than every STABLE_SAMPLES ticks never changes sw_stable.
  - Switches already high at reset release produce a rise pulse once debounced. Required: the Processor treats this as power-on state.
  - Simultaneous changes on several bits are handled independently; multiple rise/fall bits may pulse in the same cycle.
  - Reset mid-window discards partial history; no pulse is emitted by reset itself.
  - Between ticks, no state except the prescaler and the synchroniser changes.

Decomposition:
- Shared package gpio_pkg:
  - CLK_HZ = 50_000_000.
  - DEBOUNCE_MS = 1.
  - Derived default TICK_DIV.
  - Switch-bit index constants used by the Processor: SW_RUN = 0, SW_STEP = 1, SW_CPU_RESET = 2.
- One sub-module is natural: debounce_cell.
  - Holds one bit's history, stable flag and rise/fall flops; takes tick and sync2 bit.
  - Generated WIDTH times.
- Prescaler and synchroniser stay in the top.

Test Plan (bench uses WIDTH=4, TICK_DIV=4, STABLE_SAMPLES=3):
- Reset: hold reset, drive sw_raw=4'hF → all outputs 0. Release → first sample_tick exactly 4 cycles later, then every 4 cycles.
- Clean rise: sw_raw[0] 0→1 held → sw_stable[0]=1 within 11–14 cycles. sw_rise[0] and any_change high for exactly 1 cycle, coincident with the sw_stable edge. sw_fall stays 0.
- Bounce rejection: toggle sw_raw[1] every 5 cycles for 60 cycles, then hold 0 → sw_stable[1] stays 0 and no pulses at any time.
- Clean fall: with sw_stable[2]=1, drive sw_raw[2]=0 → sw_fall[2] pulses once. sw_stable[2]=0 within 11–14 cycles.
- Simultaneous bits: sw_raw 4'b0000→4'b1010 in one cycle → sw_rise=4'b1010 in the same single cycle.
- Reset mid-window: sw_raw[3]=1 held for 2 ticks, assert reset for 1 cycle, keep sw_raw[3]=1 → no pulse at reset. Rise arrives 3 full ticks after release.
